// File: rtl/tdm_demux.sv
// Receive side of the 4-channel TDM link: gathers slot words a..d and publishes whole frames.
// Optional macro TDM_DEMUX_SYNC_CHECK_EN turns an unsynced slot-0 beat into a framing error.
module tdm_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic [WIDTH-1:0] dout_c,
    output logic [WIDTH-1:0] dout_d,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [1:0]       slot_nxt;
    logic             ld_a, ld_b, ld_c, ld_out, err;
    logic [WIDTH-1:0] stage_a, stage_b, stage_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            slot  <= 2'b00;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_c      = 1'b0;
        ld_out    = 1'b0;
        err       = 1'b0;
        case (state)
            HUNT: begin
                if (din_valid && sync) begin
                    ld_a      = 1'b1;
                    slot_nxt  = 2'b01;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    if (sync) begin
                        // A sync anywhere but slot 0 drops the partial frame and restarts it.
                        err      = (slot != 2'b00);
                        ld_a     = 1'b1;
                        slot_nxt = 2'b01;
                    end else if (slot == 2'b00) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                        err       = 1'b1;
                        state_nxt = HUNT;
`else
                        ld_a     = 1'b1;
                        slot_nxt = 2'b01;
`endif
                    end else begin
                        ld_b     = (slot == 2'b01);
                        ld_c     = (slot == 2'b10);
                        ld_out   = (slot == 2'b11);
                        slot_nxt = slot + 2'd1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_a     <= '0;
            stage_b     <= '0;
            stage_c     <= '0;
            dout_a      <= '0;
            dout_b      <= '0;
            dout_c      <= '0;
            dout_d      <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= ld_out;
            sync_err    <= err;
            if (ld_a) stage_a <= din;
            if (ld_b) stage_b <= din;
            if (ld_c) stage_c <= din;
            // All four outputs move together so consumers never see a mixed frame.
            if (ld_out) begin
                dout_a <= stage_a;
                dout_b <= stage_b;
                dout_c <= stage_c;
                dout_d <= din;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
